// File: rtl/lsu_bus_if.sv
// LSU-to-bus adapter: lane-shifts byte-mask loads/stores onto a req/ack word bus, realigns read data.
// Latency: issue cycle + 1 REQ cycle per bus cycle; stall holds the pipeline until DONE, timeout after TIMEOUT cycles.
module lsu_bus_if #(
  parameter int XLEN      = 32,
  parameter int MAX_BYTES = XLEN / 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [MAX_BYTES-1:0] i_mem_r,
  input  logic [MAX_BYTES-1:0] i_mem_w,
  input  logic [XLEN-1:0]      i_addr,
  input  logic [XLEN-1:0]      i_store_data,
  output logic [XLEN-1:0]      o_mem_dout,
  output logic                 o_stall,
  output logic                 o_misaligned,
  output logic                 o_bus_err,
  output logic                 o_bus_req,
  output logic                 o_bus_we,
  output logic [XLEN-1:0]      o_bus_addr,
  output logic [MAX_BYTES-1:0] o_bus_be,
  output logic [XLEN-1:0]      o_bus_wdata,
  input  logic                 i_bus_ack,
  input  logic [XLEN-1:0]      i_bus_rdata
);

  localparam int OFFW = $clog2(MAX_BYTES);
  localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;

  typedef struct packed {
    logic                 we;
    logic [XLEN-1:0]      addr;
    logic [MAX_BYTES-1:0] be;
    logic [XLEN-1:0]      wdata;
  } bus_cmd_t;

  state_t           r_state;
  bus_cmd_t         r_cmd;
  logic             r_bus_req;
  logic             r_bus_err;
  logic [XLEN-1:0]  r_mem_dout;
  logic [OFFW-1:0]  r_off;
  logic [CNTW-1:0]  r_cnt;

  logic                 w_access;
  logic                 w_we;
  logic [MAX_BYTES-1:0] w_mask;
  logic [OFFW-1:0]      w_off;
  logic [OFFW-1:0]      w_need;
  logic                 w_mis;
  logic                 w_issue;
  logic                 w_timeout;
  bus_cmd_t             w_cmd;
  logic [XLEN-1:0]      w_rdata_al;

  // Natural alignment: the highest set mask bit fixes the access size, whose low offset bits must be zero.
  always_comb begin
    w_access = (|i_mem_r) || (|i_mem_w);
    w_we     = |i_mem_w;
    w_mask   = w_we ? i_mem_w : i_mem_r;
    w_off    = i_addr[OFFW-1:0];
    w_need   = '0;
    for (int i = 1; i < MAX_BYTES; i++) begin
      if (w_mask[i]) w_need = w_need | OFFW'((1 << $clog2(i + 1)) - 1);
    end
    w_mis   = |(w_off & w_need);
    w_issue = (r_state == ST_IDLE) && w_access && !w_mis;
  end

  always_comb begin
    w_cmd.we    = w_we;
    w_cmd.addr  = {i_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
    w_cmd.be    = w_mask << w_off;
    w_cmd.wdata = i_store_data << {w_off, 3'b000};
    w_rdata_al  = i_bus_rdata >> {r_off, 3'b000};
    w_timeout   = (r_cnt == CNTW'(TIMEOUT - 1));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_cmd      <= '0;
      r_bus_req  <= 1'b0;
      r_bus_err  <= 1'b0;
      r_mem_dout <= '0;
      r_off      <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_cmd     <= w_cmd;
            r_off     <= w_off;
            r_bus_req <= 1'b1;
            r_cnt     <= '0;
            r_state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Ack has priority over a timeout landing in the same cycle.
          if (i_bus_ack) begin
            r_bus_req <= 1'b0;
            if (!r_cmd.we) r_mem_dout <= w_rdata_al;
            r_state <= ST_DONE;
          end else if (w_timeout) begin
            r_bus_req <= 1'b0;
            r_bus_err <= 1'b1;
            if (!r_cmd.we) r_mem_dout <= '0;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNTW'(1);
          end
        end
        ST_DONE: begin
          r_bus_err <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_stall      = w_issue || (r_state == ST_REQ);
  assign o_misaligned = (r_state == ST_IDLE) && w_access && w_mis;
  assign o_bus_err    = r_bus_err;
  assign o_bus_req    = r_bus_req;
  assign o_bus_we     = r_cmd.we;
  assign o_bus_addr   = r_cmd.addr;
  assign o_bus_be     = r_cmd.be;
  assign o_bus_wdata  = r_cmd.wdata;
  assign o_mem_dout   = r_mem_dout;

endmodule

// File: tb/tb_lsu_bus_if.sv
// Bench for lsu_bus_if: directed cases then random transactions against an arithmetic reference.
module tb_lsu_bus_if;
  localparam int XLEN = 32;
  localparam int NB   = 4;
  localparam int TMO  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NB-1:0]   mem_r, mem_w;
  logic [XLEN-1:0] addr, store_data, bus_rdata;
  logic            bus_ack;
  logic [XLEN-1:0] mem_dout, bus_addr, bus_wdata;
  logic            stall, misaligned, bus_err, bus_req, bus_we;
  logic [NB-1:0]   bus_be;

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] exp_dout;

  always #5 clk = ~clk;

  lsu_bus_if #(.XLEN(XLEN), .MAX_BYTES(NB), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_mem_r(mem_r), .i_mem_w(mem_w), .i_addr(addr),
    .i_store_data(store_data), .o_mem_dout(mem_dout), .o_stall(stall),
    .o_misaligned(misaligned), .o_bus_err(bus_err), .o_bus_req(bus_req),
    .o_bus_we(bus_we), .o_bus_addr(bus_addr), .o_bus_be(bus_be),
    .o_bus_wdata(bus_wdata), .i_bus_ack(bus_ack), .i_bus_rdata(bus_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One LSU access; waits >= TMO means the bus never acks.
  task automatic xact(input logic [3:0] r, input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] sd, input logic [31:0] rd, input int waits);
    logic [3:0]  mask;
    logic        we, mis, tmo, ack;
    int          size, off, ncyc;
    logic [31:0] e_be, e_wdata, e_addr;
    we    = (w != 4'd0);
    mask  = we ? w : r;
    off   = int'(a[1:0]);
    size  = (mask > 4'd3) ? 4 : ((mask > 4'd1) ? 2 : 1);
    mis   = (off % size) != 0;
    tmo   = waits >= TMO;
    ncyc  = tmo ? TMO : waits + 1;
    e_addr  = a - 32'(off);
    e_be    = 32'(mask) << off;
    e_wdata = sd << (8 * off);

    @(negedge clk);
    mem_r = r; mem_w = w; addr = a; store_data = sd; bus_ack = 1'b0;
    #1;
    check("misaligned_issue", 32'(misaligned), 32'(mis));
    check("stall_issue", 32'(stall), 32'(!mis));
    check("req_issue", 32'(bus_req), 32'd0);
    if (mis) begin
      @(negedge clk);
      mem_r = '0; mem_w = '0;
      #1;
      check("req_after_mis", 32'(bus_req), 32'd0);
      check("stall_after_mis", 32'(stall), 32'd0);
      check("dout_after_mis", mem_dout, exp_dout);
    end else begin
      for (int k = 0; k < ncyc; k++) begin
        @(negedge clk);
        mem_r = '0; mem_w = '0; addr = $urandom; store_data = $urandom;
        ack = !tmo && (k == waits);
        bus_ack = ack;
        bus_rdata = ack ? rd : $urandom;
        #1;
        check("stall_req", 32'(stall), 32'd1);
        check("bus_req", 32'(bus_req), 32'd1);
        check("bus_addr", bus_addr, e_addr);
        check("bus_be", 32'(bus_be), e_be);
        check("bus_wdata", bus_wdata, e_wdata);
        check("bus_we", 32'(bus_we), 32'(we));
      end
      if (!we) exp_dout = tmo ? 32'd0 : (rd >> (8 * off));
      @(negedge clk);
      bus_ack = 1'b0;
      #1;
      check("stall_done", 32'(stall), 32'd0);
      check("req_done", 32'(bus_req), 32'd0);
      check("err_done", 32'(bus_err), 32'(tmo));
      check("dout_done", mem_dout, exp_dout);
      @(negedge clk);
      #1;
      check("err_idle", 32'(bus_err), 32'd0);
      check("stall_idle", 32'(stall), 32'd0);
      check("req_idle", 32'(bus_req), 32'd0);
    end
  endtask

  initial begin
    logic [3:0] masks [4];
    logic [3:0] r, w;
    masks = '{4'h0, 4'h1, 4'h3, 4'hF};
    rst = 1'b1; mem_r = '0; mem_w = '0; addr = '0; store_data = '0;
    bus_ack = 1'b0; bus_rdata = '0; exp_dout = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", 32'(bus_req), 32'd0);
    check("rst_we", 32'(bus_we), 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_be", 32'(bus_be), 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);
    check("rst_dout", mem_dout, 32'd0);
    check("rst_err", 32'(bus_err), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_mis", 32'(misaligned), 32'd0);
    rst = 1'b0;

    // Stray ack while idle
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    #1;
    check("idle_ack_stall", 32'(stall), 32'd0);
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check("idle_ack_req", 32'(bus_req), 32'd0);
    check("idle_ack_dout", mem_dout, 32'd0);

    xact(4'h1, 4'h0, 32'h103, 32'h0, 32'hAABBCCDD, 0);
    check("byte_read_aa", mem_dout, 32'h000000AA);
    xact(4'h0, 4'h3, 32'h202, 32'h00001234, $urandom, 0);
    xact(4'hF, 4'h0, 32'h101, 32'h0, $urandom, 0);
    xact(4'h3, 4'h0, 32'h103, 32'h0, $urandom, 0);
    xact(4'hF, 4'h0, 32'h0, 32'h0, $urandom, 3);
    xact(4'hF, 4'h0, 32'h40, 32'h0, $urandom, TMO);
    xact(4'h1, 4'h0, 32'h41, 32'h0, $urandom, 0);

    // Reset during the second REQ cycle, ack arrives afterwards
    @(negedge clk);
    mem_r = 4'hF; addr = 32'h0;
    @(negedge clk);
    mem_r = '0;
    #1;
    check("rstmid_req1", 32'(bus_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid_req2", 32'(bus_req), 32'd1);
    @(negedge clk);
    rst = 1'b0; bus_ack = 1'b1; bus_rdata = $urandom;
    #1;
    check("rstmid_req_low", 32'(bus_req), 32'd0);
    check("rstmid_stall", 32'(stall), 32'd0);
    check("rstmid_dout", mem_dout, 32'd0);
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check("rstmid_ack_ignored", 32'(bus_req), 32'd0);
    check("rstmid_dout2", mem_dout, 32'd0);
    check("rstmid_err", 32'(bus_err), 32'd0);
    exp_dout = '0;

    for (int n = 0; n < 40; n++) begin
      r = masks[$urandom_range(0, 3)];
      w = masks[$urandom_range(0, 3)];
      if (r == 4'h0 && w == 4'h0) r = 4'h1;
      xact(r, w, $urandom & 32'hFFFF, $urandom, $urandom, int'($urandom_range(0, 5)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_bus_if.md
Name: lsu_bus_if

Overview:
- Sequential memory-port adapter directly downstream of the load/store unit.
- Takes the LSU's byte-mask requests (mem_r / mem_w, lane-0 aligned), address and store data, and shifts them onto the correct byte lanes of a word-wide request/acknowledge data bus.
- Returns the read word realigned to lane 0 as mem_dout for the LSU's sign/zero extension.
- Stalls the pipeline while a transaction is outstanding; flags misaligned accesses and bus timeouts.

Parameters:
XLEN, 32, data/address width
MAX_BYTES, XLEN/8, byte lanes per bus word
TIMEOUT, 255, cycles in REQ without bus_ack before bus error (min 1)

Ports:
clk  in  1  clock
rst  in  1  reset
mem_r  in  MAX_BYTES  read byte mask from LSU, lane-0 aligned
mem_w  in  MAX_BYTES  write byte mask from LSU, lane-0 aligned
addr  in  XLEN  byte address of access
store_data  in  XLEN  store data, lane-0 aligned
mem_dout  out  XLEN  read data shifted to lane 0 (to LSU)
stall  out  1  hold pipeline
misaligned  out  1  access violates natural alignment
bus_err  out  1  one-cycle timeout pulse
bus_req  out  1  bus request valid
bus_we  out  1  1 = write
bus_addr  out  XLEN  word-aligned address (addr[1:0] = 0)
bus_be  out  MAX_BYTES  byte enables, shifted to lanes
bus_wdata  out  XLEN  write data, shifted to lanes
bus_ack  in  1  bus completes transaction (single cycle)
bus_rdata  in  XLEN  read word, valid with bus_ack

Behaviour:
- Clock: single clock clk, rising edge. Reset: rst is synchronous, active-high.
- Reset values: state IDLE, bus_req 0, bus_we 0, bus_addr 0, bus_be 0, bus_wdata 0, mem_dout 0, bus_err 0, timeout counter 0. stall and misaligned are combinational and read 0 in IDLE with no access.
- Definitions:
  - access = |mem_r | |mem_w.
  - If both masks are nonzero, the write wins: mask = mem_w, we = 1. Otherwise mask is whichever mask is nonzero.
  - off = addr[1:0].
- Misalignment:
  - Mask 'b11 requires off[0] = 0.
  - Mask 'b1111 requires off = 0.
  - Mask 'b1 is always aligned.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - access and aligned:
    - stall = 1 (combinational).
    - Register bus_addr = {addr[XLEN-1:2], 2'b00}, bus_be = mask << off, bus_wdata = store_data << 8*off, bus_we = we.
    - Set bus_req = 1, clear counter, go to REQ.
  - access and misaligned: misaligned = 1 and stall = 0 in the same cycle. No bus activity; stay in IDLE.
  - no access: stall = 0, idle.
  - bus_ack in IDLE is ignored.
- REQ:
  - stall = 1. bus_req, bus_we, bus_addr, bus_be and bus_wdata are held stable until the cycle bus_ack is sampled high.
  - bus_ack = 1: bus_req drops next cycle. For reads, mem_dout <= bus_rdata >> 8*off, using the off captured at issue. Go to DONE.
  - No ack: counter increments. When counter reaches TIMEOUT-1 with no ack: bus_err = 1 for the following cycle, bus_req drops, mem_dout <= 0, go to DONE.
- DONE:
  - stall = 0; mem_dout valid; the pipeline advances on this edge.
  - Inputs are ignored; next state is IDLE. There is no back-to-back issue from DONE.
  - bus_err is cleared on leaving DONE.
- mem_dout holds its value until the next read completion or reset. Writes do not change mem_dout.
- Latency: with zero wait states, bus_req is high 1 cycle and stall is high 2 cycles. Each bus wait state adds 1 stall cycle.
- Reset mid-transaction: bus_req is low the cycle after rst. An ack arriving after reset lands in IDLE and is ignored.
- Address offset is captured at issue; later changes on addr during REQ have no effect.

Test Plan:
- Read at addr 0x103, mask 'b1, ack 1 cycle after bus_req, bus_rdata 0xAABBCCDD -> bus_addr 0x100, bus_be 'b1000, bus_we 0, mem_dout[7:0] = 0xAA in DONE, stall high exactly 2 cycles.
- Write at 0x202, mask 'b11, store_data 0x00001234 -> bus_be 'b1100, bus_wdata 0x12340000, bus_we 1, mem_dout unchanged.
- Read at 0x101, mask 'b1111 -> misaligned 1 same cycle, stall 0, bus_req never asserts. Also read at 0x103, mask 'b11 -> misaligned 1.
- Read at 0x0, ack after 3 wait states -> bus_req high 4 cycles with outputs stable, stall high 5 cycles.
- TIMEOUT = 4, no ack -> bus_req high 4 cycles, bus_err pulses 1 cycle, mem_dout = 0, stall released, next access issues normally.
- rst asserted in 2nd REQ cycle, then ack the following cycle -> bus_req 0, state IDLE, mem_dout 0, ack ignored.
